// File: rtl/axi2native_slave_pkg.sv
// Shared AXI constants and FSM state type for the axi2native slave.
package axi2native_slave_pkg;

  localparam logic [1:0] AXI_RESP_OKAY   = 2'b00;
  localparam logic [1:0] AXI_RESP_SLVERR = 2'b10;

  localparam logic [1:0] AXI_BURST_FIXED = 2'b00;
  localparam logic [1:0] AXI_BURST_INCR  = 2'b01;
  localparam logic [1:0] AXI_BURST_WRAP  = 2'b10;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_W_DATA,
    ST_W_MEM,
    ST_W_RESP,
    ST_R_MEM,
    ST_R_DATA
  } state_t;

  // Unsupported burst: narrow/wide size, or WRAP / reserved burst type.
  function automatic logic burst_cfg_err(input logic [2:0] size,
                                         input logic [1:0] burst,
                                         input logic [2:0] size_ok);
    return (size != size_ok) || burst[1];
  endfunction

endpackage

// File: rtl/axi_burst_addr_gen.sv
// Burst address generator: word-aligned address, beat counter, last-beat flag.
module axi_burst_addr_gen
  import axi2native_slave_pkg::*;
#(
  parameter int unsigned ADDR_W = 24,
  parameter int unsigned DATA_W = 32
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              load,
  input  logic [ADDR_W-1:0] load_addr,
  input  logic [1:0]        load_burst,
  input  logic [7:0]        load_len,
  input  logic              step,
  output logic [ADDR_W-1:0] addr,
  output logic              is_last
);

  localparam int unsigned BYTES = DATA_W / 8;
  localparam logic [ADDR_W-1:0] ALIGN_MASK = ~ADDR_W'(BYTES - 1);

  logic [ADDR_W-1:0] addr_q;
  logic [1:0]        burst_q;
  logic [7:0]        len_q;
  logic [7:0]        beat_q;

  // Load on address accept, advance one beat per step; INCR wraps modulo 2^ADDR_W.
  always_ff @(posedge clk) begin
    if (rst) begin
      addr_q  <= '0;
      burst_q <= '0;
      len_q   <= '0;
      beat_q  <= '0;
    end else if (load) begin
      addr_q  <= load_addr & ALIGN_MASK;
      burst_q <= load_burst;
      len_q   <= load_len;
      beat_q  <= '0;
    end else if (step) begin
      beat_q <= beat_q + 8'd1;
      if (burst_q == AXI_BURST_INCR)
        addr_q <= addr_q + ADDR_W'(BYTES);
    end
  end

  assign addr    = addr_q;
  assign is_last = (beat_q == len_q);

endmodule

// File: rtl/axi2native_slave.sv
// AXI4 slave converting FIXED/INCR bursts into single-word native accesses.
module axi2native_slave
  import axi2native_slave_pkg::*;
#(
  parameter int unsigned ADDR_W = 24,
  parameter int unsigned DATA_W = 32,
  parameter int unsigned ID_W   = 1
) (
  input  logic                clk,
  input  logic                rst,
  input  logic [ID_W-1:0]     axi_awid,
  input  logic [ADDR_W-1:0]   axi_awaddr,
  input  logic [7:0]          axi_awlen,
  input  logic [2:0]          axi_awsize,
  input  logic [1:0]          axi_awburst,
  input  logic                axi_awvalid,
  output logic                axi_awready,
  input  logic [DATA_W-1:0]   axi_wdata,
  input  logic [DATA_W/8-1:0] axi_wstrb,
  input  logic                axi_wlast,
  input  logic                axi_wvalid,
  output logic                axi_wready,
  output logic [ID_W-1:0]     axi_bid,
  output logic [1:0]          axi_bresp,
  output logic                axi_bvalid,
  input  logic                axi_bready,
  input  logic [ID_W-1:0]     axi_arid,
  input  logic [ADDR_W-1:0]   axi_araddr,
  input  logic [7:0]          axi_arlen,
  input  logic [2:0]          axi_arsize,
  input  logic [1:0]          axi_arburst,
  input  logic                axi_arvalid,
  output logic                axi_arready,
  output logic [ID_W-1:0]     axi_rid,
  output logic [DATA_W-1:0]   axi_rdata,
  output logic [1:0]          axi_rresp,
  output logic                axi_rlast,
  output logic                axi_rvalid,
  input  logic                axi_rready,
  output logic                valid,
  output logic [ADDR_W-1:0]   addr,
  output logic [DATA_W-1:0]   wdata,
  output logic [DATA_W/8-1:0] wstrb,
  input  logic [DATA_W-1:0]   rdata,
  input  logic                ready
);

  localparam logic [2:0] SIZE_OK = 3'($clog2(DATA_W / 8));

  state_t state_q, state_d;

  logic                awready_q, arready_q, last_rd_q;
  logic [ID_W-1:0]     id_q;
  logic                err_q;     // unsupported size/burst: suppress native accesses
  logic                wl_err_q;  // wlast misplaced: response only
  logic [DATA_W-1:0]   wdata_q;
  logic [DATA_W/8-1:0] wstrb_q;
  logic [DATA_W-1:0]   rdata_q;

  logic aw_hs, ar_hs, skip_w, gen_step, gen_last;
  logic [ADDR_W-1:0] gen_addr;

  assign aw_hs  = axi_awvalid & awready_q;
  assign ar_hs  = axi_arvalid & arready_q;
  assign skip_w = err_q | (axi_wstrb == '0);

  axi_burst_addr_gen #(
    .ADDR_W (ADDR_W),
    .DATA_W (DATA_W)
  ) u_addr_gen (
    .clk        (clk),
    .rst        (rst),
    .load       (aw_hs | ar_hs),
    .load_addr  (aw_hs ? axi_awaddr  : axi_araddr),
    .load_burst (aw_hs ? axi_awburst : axi_arburst),
    .load_len   (aw_hs ? axi_awlen   : axi_arlen),
    .step       (gen_step),
    .addr       (gen_addr),
    .is_last    (gen_last)
  );

  // State register.
  always_ff @(posedge clk) begin
    if (rst) state_q <= ST_IDLE;
    else     state_q <= state_d;
  end

  // Registered address-channel readies with alternating priority when both request.
  // The ready is raised one cycle after the valid is seen and is held for one cycle only.
  always_ff @(posedge clk) begin
    if (rst) begin
      awready_q <= 1'b0;
      arready_q <= 1'b0;
      last_rd_q <= 1'b1;
    end else begin
      awready_q <= 1'b0;
      arready_q <= 1'b0;
      if (state_q == ST_IDLE && !awready_q && !arready_q) begin
        if (axi_awvalid && (!axi_arvalid || last_rd_q)) awready_q <= 1'b1;
        else if (axi_arvalid)                           arready_q <= 1'b1;
      end
      if (aw_hs) last_rd_q <= 1'b0;
      if (ar_hs) last_rd_q <= 1'b1;
    end
  end

  // Next-state logic; burst termination is by beat count only.
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      ST_IDLE:   if (aw_hs) state_d = ST_W_DATA;
                 else if (ar_hs) state_d = ST_R_MEM;
      ST_W_DATA: if (axi_wvalid) begin
                   if (!skip_w)      state_d = ST_W_MEM;
                   else if (gen_last) state_d = ST_W_RESP;
                 end
      ST_W_MEM:  if (ready) state_d = gen_last ? ST_W_RESP : ST_W_DATA;
      ST_W_RESP: if (axi_bready) state_d = ST_IDLE;
      ST_R_MEM:  if (err_q || ready) state_d = ST_R_DATA;
      ST_R_DATA: if (axi_rready) state_d = gen_last ? ST_IDLE : ST_R_MEM;
      default:   state_d = ST_IDLE;
    endcase
  end

  // Output decode and burst address stepping.
  always_comb begin
    axi_wready = (state_q == ST_W_DATA);
    axi_bvalid = (state_q == ST_W_RESP);
    axi_rvalid = (state_q == ST_R_DATA);
    axi_rlast  = axi_rvalid & gen_last;
    axi_bresp  = (axi_bvalid && (err_q || wl_err_q)) ? AXI_RESP_SLVERR : AXI_RESP_OKAY;
    axi_rresp  = (axi_rvalid && err_q) ? AXI_RESP_SLVERR : AXI_RESP_OKAY;
    valid      = (state_q == ST_W_MEM) || (state_q == ST_R_MEM && !err_q);
    wstrb      = (state_q == ST_W_MEM) ? wstrb_q : '0;
    gen_step   = !gen_last &&
                 ((state_q == ST_W_DATA && axi_wvalid && skip_w) ||
                  (state_q == ST_W_MEM  && ready) ||
                  (state_q == ST_R_DATA && axi_rready));
  end

  // Transaction attributes, error flags and data holding registers.
  always_ff @(posedge clk) begin
    if (rst) begin
      id_q     <= '0;
      err_q    <= 1'b0;
      wl_err_q <= 1'b0;
      wdata_q  <= '0;
      wstrb_q  <= '0;
      rdata_q  <= '0;
    end else begin
      if (aw_hs) begin
        id_q     <= axi_awid;
        err_q    <= burst_cfg_err(axi_awsize, axi_awburst, SIZE_OK);
        wl_err_q <= 1'b0;
      end else if (ar_hs) begin
        id_q     <= axi_arid;
        err_q    <= burst_cfg_err(axi_arsize, axi_arburst, SIZE_OK);
        wl_err_q <= 1'b0;
      end
      if (state_q == ST_W_DATA && axi_wvalid) begin
        if (axi_wlast != gen_last) wl_err_q <= 1'b1;
        if (!skip_w) begin
          wdata_q <= axi_wdata;
          wstrb_q <= axi_wstrb;
        end
      end
      if (state_q == ST_R_MEM) begin
        if (err_q)      rdata_q <= '0;
        else if (ready) rdata_q <= rdata;
      end
    end
  end

  assign axi_awready = awready_q;
  assign axi_arready = arready_q;
  assign axi_bid     = id_q;
  assign axi_rid     = id_q;
  assign axi_rdata   = rdata_q;
  assign addr        = gen_addr;
  assign wdata       = wdata_q;

endmodule

// File: tb/tb_axi2native_slave.sv
// Directed bench for axi2native_slave with a one-cycle native memory responder.
module tb_axi2native_slave;
  import axi2native_slave_pkg::*;

  logic        clk = 1'b0;
  logic        rst;
  logic [0:0]  axi_awid, axi_bid, axi_arid, axi_rid;
  logic [23:0] axi_awaddr, axi_araddr, addr;
  logic [7:0]  axi_awlen, axi_arlen;
  logic [2:0]  axi_awsize, axi_arsize;
  logic [1:0]  axi_awburst, axi_arburst, axi_bresp, axi_rresp;
  logic        axi_awvalid, axi_awready, axi_wlast, axi_wvalid, axi_wready;
  logic        axi_bvalid, axi_bready, axi_arvalid, axi_arready;
  logic        axi_rlast, axi_rvalid, axi_rready, valid, ready;
  logic [31:0] axi_wdata, axi_rdata, wdata, rdata;
  logic [3:0]  axi_wstrb, wstrb;

  logic [23:0] log_addr[$];
  logic [3:0]  log_strb[$];
  logic [31:0] log_data[$];

  int n_checks = 0;
  int n_fail   = 0;

  always #5 clk = ~clk;

  axi2native_slave #(.ADDR_W(24), .DATA_W(32), .ID_W(1)) dut (
    .clk(clk), .rst(rst),
    .axi_awid(axi_awid), .axi_awaddr(axi_awaddr), .axi_awlen(axi_awlen),
    .axi_awsize(axi_awsize), .axi_awburst(axi_awburst),
    .axi_awvalid(axi_awvalid), .axi_awready(axi_awready),
    .axi_wdata(axi_wdata), .axi_wstrb(axi_wstrb), .axi_wlast(axi_wlast),
    .axi_wvalid(axi_wvalid), .axi_wready(axi_wready),
    .axi_bid(axi_bid), .axi_bresp(axi_bresp), .axi_bvalid(axi_bvalid),
    .axi_bready(axi_bready),
    .axi_arid(axi_arid), .axi_araddr(axi_araddr), .axi_arlen(axi_arlen),
    .axi_arsize(axi_arsize), .axi_arburst(axi_arburst),
    .axi_arvalid(axi_arvalid), .axi_arready(axi_arready),
    .axi_rid(axi_rid), .axi_rdata(axi_rdata), .axi_rresp(axi_rresp),
    .axi_rlast(axi_rlast), .axi_rvalid(axi_rvalid), .axi_rready(axi_rready),
    .valid(valid), .addr(addr), .wdata(wdata), .wstrb(wstrb),
    .rdata(rdata), .ready(ready)
  );

  // Native memory: ready pulse the cycle after valid, read data derived from address.
  always @(posedge clk) begin
    ready <= 1'b0;
    if (valid && !ready) begin
      ready <= 1'b1;
      rdata <= 32'hA500_0000 | 32'(addr);
      log_addr.push_back(addr);
      log_strb.push_back(wstrb);
      log_data.push_back(wdata);
    end
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic clear_log();
    log_addr.delete();
    log_strb.delete();
    log_data.delete();
  endtask

  task automatic do_aw(input logic id, input logic [23:0] a, input logic [7:0] len,
                       input logic [2:0] size, input logic [1:0] burst);
    int n = 0;
    axi_awid = id; axi_awaddr = a; axi_awlen = len; axi_awsize = size; axi_awburst = burst;
    axi_awvalid = 1'b1;
    while (!axi_awready && n < 50) begin tick(); n++; end
    check("aw_handshake", 32'(axi_awready), 32'd1);
    tick();
    axi_awvalid = 1'b0;
  endtask

  task automatic do_ar(input logic id, input logic [23:0] a, input logic [7:0] len,
                       input logic [2:0] size, input logic [1:0] burst);
    int n = 0;
    axi_arid = id; axi_araddr = a; axi_arlen = len; axi_arsize = size; axi_arburst = burst;
    axi_arvalid = 1'b1;
    while (!axi_arready && n < 50) begin tick(); n++; end
    check("ar_handshake", 32'(axi_arready), 32'd1);
    tick();
    axi_arvalid = 1'b0;
  endtask

  task automatic do_w(input int len, input logic [3:0] s0, input logic [3:0] srest,
                      input int wlast_at);
    for (int i = 0; i <= len; i++) begin
      int n = 0;
      axi_wvalid = 1'b1;
      axi_wdata  = 32'hCAFE_0000 | 32'(i);
      axi_wstrb  = (i == 0) ? s0 : srest;
      axi_wlast  = (i == wlast_at);
      while (!axi_wready && n < 50) begin tick(); n++; end
      check("w_handshake", 32'(axi_wready), 32'd1);
      tick();
    end
    axi_wvalid = 1'b0;
    axi_wlast  = 1'b0;
  endtask

  task automatic get_b(input logic id, input logic [1:0] resp);
    int n = 0;
    axi_bready = 1'b1;
    while (!axi_bvalid && n < 50) begin tick(); n++; end
    check("b_valid", 32'(axi_bvalid), 32'd1);
    check("b_id", 32'(axi_bid), 32'(id));
    check("b_resp", 32'(axi_bresp), 32'(resp));
    tick();
    axi_bready = 1'b0;
  endtask

  task automatic get_r(input logic id, input logic [23:0] base, input int len,
                       input bit fixed, input bit err);
    axi_rready = 1'b1;
    for (int i = 0; i <= len; i++) begin
      int n = 0;
      logic [23:0] a;
      a = fixed ? base : base + 24'(4 * i);
      while (!axi_rvalid && n < 50) begin tick(); n++; end
      check("r_valid", 32'(axi_rvalid), 32'd1);
      check("r_data", axi_rdata, err ? 32'h0 : (32'hA500_0000 | 32'(a)));
      check("r_resp", 32'(axi_rresp), err ? 32'h2 : 32'h0);
      check("r_last", 32'(axi_rlast), 32'(i == len));
      check("r_id", 32'(axi_rid), 32'(id));
      tick();
    end
    axi_rready = 1'b0;
  endtask

  task automatic check_log(input int idx, input logic [23:0] a, input logic [3:0] s,
                           input logic [31:0] d);
    if (idx < log_addr.size()) begin
      check("nat_addr", 32'(log_addr[idx]), 32'(a));
      check("nat_strb", 32'(log_strb[idx]), 32'(s));
      if (s != 4'h0) check("nat_wdata", log_data[idx], d);
    end else begin
      check("nat_present", 32'(log_addr.size()), 32'(idx + 1));
    end
  endtask

  task automatic check_idle_outputs(input string tag);
    check({tag, "_awready"}, 32'(axi_awready), 0);
    check({tag, "_arready"}, 32'(axi_arready), 0);
    check({tag, "_wready"},  32'(axi_wready), 0);
    check({tag, "_bvalid"},  32'(axi_bvalid), 0);
    check({tag, "_rvalid"},  32'(axi_rvalid), 0);
    check({tag, "_rlast"},   32'(axi_rlast), 0);
    check({tag, "_valid"},   32'(valid), 0);
    check({tag, "_addr"},    32'(addr), 0);
    check({tag, "_wstrb"},   32'(wstrb), 0);
    check({tag, "_wdata"},   wdata, 0);
    check({tag, "_rdata"},   axi_rdata, 0);
    check({tag, "_resp"},    32'({axi_bresp, axi_rresp}), 0);
  endtask

  initial begin
    rst = 1'b1;
    axi_awid = '0; axi_awaddr = '0; axi_awlen = '0; axi_awsize = '0; axi_awburst = '0;
    axi_awvalid = 1'b0; axi_wdata = '0; axi_wstrb = '0; axi_wlast = 1'b0; axi_wvalid = 1'b0;
    axi_bready = 1'b0; axi_arid = '0; axi_araddr = '0; axi_arlen = '0; axi_arsize = '0;
    axi_arburst = '0; axi_arvalid = 1'b0; axi_rready = 1'b0;
    repeat (3) tick();
    rst = 1'b0;
    check_idle_outputs("reset");

    // Simultaneous AW/AR after reset: write wins, then read wins.
    begin
      int n = 0;
      clear_log();
      axi_awid = 1'b0; axi_awaddr = 24'h500; axi_awlen = 8'd0; axi_awsize = 3'd2;
      axi_awburst = AXI_BURST_INCR;
      axi_arid = 1'b1; axi_araddr = 24'h600; axi_arlen = 8'd0; axi_arsize = 3'd2;
      axi_arburst = AXI_BURST_INCR;
      axi_awvalid = 1'b1; axi_arvalid = 1'b1;
      while (!axi_awready && !axi_arready && n < 50) begin tick(); n++; end
      check("arb1_awready", 32'(axi_awready), 1);
      check("arb1_arready", 32'(axi_arready), 0);
      axi_arvalid = 1'b0;
      tick();
      axi_awvalid = 1'b0;
      do_w(0, 4'hF, 4'hF, 0);
      get_b(1'b0, AXI_RESP_OKAY);
      check("arb1_nat_count", 32'(log_addr.size()), 1);
      check_log(0, 24'h500, 4'hF, 32'hCAFE_0000);

      n = 0;
      clear_log();
      axi_awvalid = 1'b1; axi_arvalid = 1'b1;
      while (!axi_awready && !axi_arready && n < 50) begin tick(); n++; end
      check("arb2_arready", 32'(axi_arready), 1);
      check("arb2_awready", 32'(axi_awready), 0);
      axi_awvalid = 1'b0;
      tick();
      axi_arvalid = 1'b0;
      get_r(1'b1, 24'h600, 0, 1'b0, 1'b0);
    end

    // INCR read burst of 4.
    clear_log();
    do_ar(1'b1, 24'h100, 8'd3, 3'd2, AXI_BURST_INCR);
    get_r(1'b1, 24'h100, 3, 1'b0, 1'b0);
    check("rd4_nat_count", 32'(log_addr.size()), 4);
    for (int i = 0; i < 4; i++) check_log(i, 24'h100 + 24'(4 * i), 4'h0, 32'h0);

    // FIXED write burst of 2 with partial strobe.
    clear_log();
    do_aw(1'b0, 24'h200, 8'd1, 3'd2, AXI_BURST_FIXED);
    do_w(1, 4'hF, 4'h3, 1);
    get_b(1'b0, AXI_RESP_OKAY);
    check("wrfix_nat_count", 32'(log_addr.size()), 2);
    check_log(0, 24'h200, 4'hF, 32'hCAFE_0000);
    check_log(1, 24'h200, 4'h3, 32'hCAFE_0001);

    // Unsupported size on write, WRAP on read: no native traffic, SLVERR.
    clear_log();
    do_aw(1'b1, 24'h300, 8'd2, 3'd1, AXI_BURST_INCR);
    do_w(2, 4'hF, 4'hF, 2);
    get_b(1'b1, AXI_RESP_SLVERR);
    do_ar(1'b0, 24'h340, 8'd1, 3'd2, AXI_BURST_WRAP);
    get_r(1'b0, 24'h340, 1, 1'b0, 1'b1);
    check("err_nat_count", 32'(log_addr.size()), 0);

    // Address wrap at top of space, early wlast.
    clear_log();
    do_aw(1'b0, 24'hFFFFFC, 8'd1, 3'd2, AXI_BURST_INCR);
    do_w(1, 4'hF, 4'hF, 0);
    get_b(1'b0, AXI_RESP_SLVERR);
    check("wrap_nat_count", 32'(log_addr.size()), 2);
    check_log(0, 24'hFFFFFC, 4'hF, 32'hCAFE_0000);
    check_log(1, 24'h000000, 4'hF, 32'hCAFE_0001);

    // R backpressure then reset mid-burst.
    begin
      int n = 0;
      clear_log();
      do_ar(1'b1, 24'h700, 8'd3, 3'd2, AXI_BURST_INCR);
      axi_rready = 1'b0;
      while (!axi_rvalid && n < 50) begin tick(); n++; end
      check("bp_rvalid", 32'(axi_rvalid), 1);
      check("bp_rdata0", axi_rdata, 32'hA500_0700);
      repeat (5) tick();
      check("bp_hold_rvalid", 32'(axi_rvalid), 1);
      check("bp_hold_rdata", axi_rdata, 32'hA500_0700);
      check("bp_hold_rlast", 32'(axi_rlast), 0);
      axi_rready = 1'b1;
      tick();
      axi_rready = 1'b0;
      n = 0;
      while (!axi_rvalid && n < 50) begin tick(); n++; end
      check("bp_rdata1", axi_rdata, 32'hA500_0704);
      rst = 1'b1;
      tick();
      rst = 1'b0;
      check_idle_outputs("midrst");
      tick();
      clear_log();
      do_ar(1'b0, 24'h400, 8'd0, 3'd2, AXI_BURST_INCR);
      get_r(1'b0, 24'h400, 0, 1'b0, 1'b0);
      check("post_rst_nat_count", 32'(log_addr.size()), 1);
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
